// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, issues one request at a time to
// a variable-latency instruction memory, and presents fetched words through
// the IF/ID register. A one-entry hold buffer absorbs a response that arrives
// while decode is stalled. Taken branches from decode redirect the PC and
// squash whatever was fetched down the wrong path.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [63:0] BusImm,
  output logic [31:0] Instruction,
  output logic [63:0] InstrPC,
  output logic        InstrValid
);

  localparam logic [63:0] STEP = 64'(PC_STEP);

  // S_ISSUE: request in flight this cycle; S_WAIT: awaiting the response;
  // S_DRAIN: awaiting a wrong-path response to throw away;
  // S_HOLD: a response is parked in the hold buffer behind a stalled IF/ID.
  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_d;
  logic [63:0] instr_pc_d;
  logic        valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [63:0] hold_pc_q, hold_pc_d;

  logic        consume;
  logic        slot_free;
  logic        redirect;
  logic [63:0] target;

  // Handshake with decode and the branch target; the add wraps modulo 2^64.
  always_comb begin
    consume   = InstrValid & ~Stall;
    slot_free = ~InstrValid | consume;
    redirect  = consume & BranchTaken;
    target    = InstrPC + BusImm;
  end

  // Memory request decodes only registered state, so no input reaches it.
  always_comb begin
    IMemReq  = (state_q == S_ISSUE);
    IMemAddr = pc_q;
  end

  // Next-state, PC, IF/ID and hold-buffer update.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = Instruction;
    instr_pc_d   = InstrPC;
    valid_d      = InstrValid & ~consume;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    unique case (state_q)
      S_ISSUE: begin
        if (redirect) begin
          // The request just issued is down the wrong path; drain it.
          pc_d    = target;
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = IMemReady ? S_ISSUE : S_DRAIN;
        end else if (IMemReady) begin
          pc_d = pc_q + STEP;
          if (slot_free) begin
            instr_d    = IMemData;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            hold_instr_d = IMemData;
            hold_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end
      end

      S_DRAIN: begin
        if (IMemReady) begin
          state_d = S_ISSUE;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          hold_instr_d = '0;
          hold_pc_d    = '0;
          pc_d         = target;
          state_d      = S_ISSUE;
        end else if (slot_free) begin
          instr_d    = hold_instr_q;
          instr_pc_d = hold_pc_q;
          valid_d    = 1'b1;
          state_d    = S_ISSUE;
        end
      end

      default: state_d = S_ISSUE;
    endcase
  end

  // State, PC, IF/ID and hold-buffer registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: the hold buffer is a handful of flops rather than a RAM, so it is
    // cleared with everything else; reset takes priority over all inputs.
    if (!Reset_L) begin
      state_q      <= S_ISSUE;
      pc_q         <= RESET_PC;
      Instruction  <= '0;
      InstrPC      <= '0;
      InstrValid   <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      Instruction  <= instr_d;
      InstrPC      <= instr_pc_d;
      InstrValid   <= valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The bench plays instruction memory
// (word at address a is 0xA0000000 + a[33:2]) with fixed or random latency,
// runs a per-cycle vector table, directed branch/reset/latency sequences, and
// a randomized run checked against a program-order model of the fetch stream.
module tb_fetch_unit;

  logic        CLK;
  logic        Reset_L;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        Stall;
  logic        BranchTaken;
  logic [63:0] BusImm;
  logic [31:0] Instruction;
  logic [63:0] InstrPC;
  logic        InstrValid;

  fetch_unit #(.RESET_PC(64'h0), .PC_STEP(4)) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemData   (IMemData),
    .Stall      (Stall),
    .BranchTaken(BranchTaken),
    .BusImm     (BusImm),
    .Instruction(Instruction),
    .InstrPC    (InstrPC),
    .InstrValid (InstrValid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Memory model state.
  bit          pend     = 1'b0;
  logic [63:0] paddr    = '0;
  int          cnt      = 0;
  int          mem_lat  = 1;
  bit          mem_rand = 1'b0;
  logic [63:0] rdy_addr = '0;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'hA000_0000 + a[33:2];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle. A request seen at the end of a cycle (and not killed by
  // reset) is answered 'latency' cycles later; inputs change at posedge+1.
  task automatic tick();
    if (!Reset_L) begin
      pend = 1'b0;
    end else if (IMemReq) begin
      check("one_outstanding", 64'(pend), 64'd0);
      pend  = 1'b1;
      paddr = IMemAddr;
      cnt   = mem_rand ? int'($urandom_range(4, 1)) : mem_lat;
    end
    @(posedge CLK);
    #1;
    IMemReady = 1'b0;
    IMemData  = $urandom;
    if (pend) begin
      if (cnt <= 1) begin
        IMemReady = 1'b1;
        IMemData  = word_at(paddr);
        rdy_addr  = paddr;
        pend      = 1'b0;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic do_reset();
    Reset_L     = 1'b0;
    Stall       = 1'b0;
    BranchTaken = 1'b0;
    BusImm      = '0;
    tick();
    tick();
    Reset_L = 1'b1;
  endtask

  // Run with no stalls until IF/ID shows the given PC.
  task automatic wait_valid_pc(input logic [63:0] pc, input int budget);
    bit found = 1'b0;
    Stall       = 1'b0;
    BranchTaken = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (InstrValid && InstrPC == pc) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wait_pc_reached", 64'(found), 64'd1);
  endtask

  // Run with no stalls until IF/ID holds anything valid.
  task automatic next_valid(input int budget);
    bit found = 1'b0;
    Stall       = 1'b0;
    BranchTaken = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (InstrValid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("next_valid_reached", 64'(found), 64'd1);
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] imm;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    IMemReady = 1'b0;
    IMemData  = '0;

    // Cycle-by-cycle vectors after reset, 1-cycle memory. Inputs are applied
    // in the listed cycle; expectations are observed at the start of it.
    // Branch requests in cycles 1 (IF/ID empty) and 5 (stalled) must be ignored.
    //            stall br  imm         req addr     vld pc      instr
    tbl[0]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h0,  1'b0, 64'h0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 64'h100, 1'b0, 64'h0,  1'b0, 64'h0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h4,  1'b1, 64'h0, 32'hA000_0000};
    tbl[3]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h4,  1'b0, 64'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 64'h0,   1'b1, 64'h8,  1'b1, 64'h4, 32'hA000_0001};
    tbl[5]  = '{1'b1, 1'b1, 64'h200, 1'b0, 64'h8,  1'b1, 64'h4, 32'hA000_0001};
    tbl[6]  = '{1'b1, 1'b0, 64'h0,   1'b0, 64'hC,  1'b1, 64'h4, 32'hA000_0001};
    tbl[7]  = '{1'b1, 1'b0, 64'h0,   1'b0, 64'hC,  1'b1, 64'h4, 32'hA000_0001};
    tbl[8]  = '{1'b1, 1'b0, 64'h0,   1'b0, 64'hC,  1'b1, 64'h4, 32'hA000_0001};
    tbl[9]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'hC,  1'b1, 64'h4, 32'hA000_0001};
    tbl[10] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'hC,  1'b1, 64'h8, 32'hA000_0002};
    tbl[11] = '{1'b0, 1'b0, 64'h0,   1'b0, 64'hC,  1'b0, 64'h0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 64'h0,   1'b1, 64'h10, 1'b1, 64'hC, 32'hA000_0003};

    // ---- Reset state and table-driven sequence --------------------------
    mem_lat  = 1;
    mem_rand = 1'b0;
    do_reset();
    check("rst_instr", 64'(Instruction), 64'd0);
    check("rst_instr_pc", InstrPC, 64'd0);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("tbl%0d_req", i), 64'(IMemReq), 64'(tbl[i].req));
      check($sformatf("tbl%0d_addr", i), IMemAddr, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), 64'(InstrValid), 64'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d_pc", i), InstrPC, tbl[i].pc);
        check($sformatf("tbl%0d_instr", i), 64'(Instruction), 64'(tbl[i].instr));
      end
      Stall       = tbl[i].stall;
      BranchTaken = tbl[i].br;
      BusImm      = tbl[i].imm;
      tick();
    end

    // ---- CBZ at 0x8 while request for 0xC is outstanding ----------------
    do_reset();
    wait_valid_pc(64'h8, 20);
    check("cbz_req_c", 64'(IMemReq), 64'd1);
    check("cbz_addr_c", IMemAddr, 64'hC);
    BranchTaken = 1'b1;
    BusImm      = 64'h40;
    tick();
    BranchTaken = 1'b0;
    check("cbz_squash_valid", 64'(InstrValid), 64'd0);
    check("cbz_drain_noreq", 64'(IMemReq), 64'd0);
    tick();
    check("cbz_next_req", 64'(IMemReq), 64'd1);
    check("cbz_next_addr", IMemAddr, 64'h48);
    next_valid(10);
    check("cbz_target_pc", InstrPC, 64'h48);
    check("cbz_target_instr", 64'(Instruction), 64'(word_at(64'h48)));

    // ---- B backwards to 0, then wrap-around below zero ------------------
    do_reset();
    wait_valid_pc(64'h10, 30);
    BranchTaken = 1'b1;
    BusImm      = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    BranchTaken = 1'b0;
    tick();
    check("b_req", 64'(IMemReq), 64'd1);
    check("b_addr_zero", IMemAddr, 64'h0);
    next_valid(10);
    check("b_pc_zero", InstrPC, 64'h0);
    BranchTaken = 1'b1;
    BusImm      = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    BranchTaken = 1'b0;
    tick();
    check("wrap_req", 64'(IMemReq), 64'd1);
    check("wrap_addr", IMemAddr, 64'hFFFF_FFFF_FFFF_FFF0);
    next_valid(10);
    check("wrap_pc", InstrPC, 64'hFFFF_FFFF_FFFF_FFF0);
    check("wrap_instr", 64'(Instruction), 64'(word_at(64'hFFFF_FFFF_FFFF_FFF0)));

    // ---- 3-cycle memory: request spacing and load timing ----------------
    begin
      int          last_req = -1;
      bit          have_rdy = 1'b0;
      logic [63:0] exp_pc   = '0;
      mem_lat = 3;
      do_reset();
      for (int k = 0; k < 30; k++) begin
        if (have_rdy) begin
          check("lat3_valid", 64'(InstrValid), 64'd1);
          check("lat3_pc", InstrPC, exp_pc);
          check("lat3_instr", 64'(Instruction), 64'(word_at(exp_pc)));
        end
        have_rdy = IMemReady;
        exp_pc   = rdy_addr;
        if (IMemReq) begin
          if (last_req >= 0) check("lat3_req_spacing", 64'(k - last_req), 64'd4);
          last_req = k;
        end
        tick();
      end
      mem_lat = 1;
    end

    // ---- Reset while waiting, with the response in the reset cycle ------
    begin
      bit found = 1'b0;
      do_reset();
      for (int k = 0; k < 20; k++) begin
        if (!IMemReq && IMemAddr == 64'h8) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      check("rstw_reached", 64'(found), 64'd1);
      check("rstw_ready_now", 64'(IMemReady), 64'd1);
      Reset_L = 1'b0;
      tick();
      Reset_L = 1'b1;
      check("rstw_valid", 64'(InstrValid), 64'd0);
      check("rstw_instr_clear", 64'(Instruction), 64'd0);
      check("rstw_req", 64'(IMemReq), 64'd1);
      check("rstw_addr", IMemAddr, 64'h0);
      next_valid(10);
      check("rstw_first_pc", InstrPC, 64'h0);
      check("rstw_first_instr", 64'(Instruction), 64'(word_at(64'h0)));
    end

    // ---- Randomized run against a program-order model -------------------
    begin
      logic [63:0] exp_pc    = 64'h0;
      bit          prev_hold = 1'b0;
      logic [63:0] prev_pc   = '0;
      logic [31:0] prev_ins  = '0;
      int          idle      = 0;
      int          consumes  = 0;
      logic [7:0]  r;
      mem_rand = 1'b1;
      do_reset();
      for (int k = 0; k < 1500; k++) begin
        if (InstrValid) idle = 0;
        else idle++;
        if (idle > 24) begin
          check("rand_progress", 64'(idle), 64'd24);
          break;
        end
        if (prev_hold) begin
          check("rand_hold_valid", 64'(InstrValid), 64'd1);
          check("rand_hold_pc", InstrPC, prev_pc);
          check("rand_hold_instr", 64'(Instruction), 64'(prev_ins));
        end
        Stall       = ($urandom_range(9, 0) < 3);
        BranchTaken = ($urandom_range(4, 0) == 0);
        r           = 8'($urandom);
        BusImm      = {{54{r[7]}}, r, 2'b00};
        if (InstrValid && !Stall) begin
          check("rand_pc", InstrPC, exp_pc);
          check("rand_instr", 64'(Instruction), 64'(word_at(exp_pc)));
          exp_pc = BranchTaken ? exp_pc + BusImm : exp_pc + 64'd4;
          consumes++;
        end
        prev_hold = InstrValid && Stall;
        prev_pc   = InstrPC;
        prev_ins  = Instruction;
        tick();
      end
      check("rand_enough_consumes", 64'(consumes >= 100), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- LEGv8 instruction-fetch stage that holds the PC, reads instructions from a variable-latency instruction memory, and presents them through an IF/ID register.
- Its Instruction output feeds the decode stage's sign extender; the sign extender's BusImm comes back to this block to form branch targets.
- It handles decode back-pressure with a one-entry hold buffer and discards wrong-path fetches when a branch is taken.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset_L  input  1  synchronous, active-low reset.
- IMemReq  output  1  one-cycle request pulse to instruction memory.
- IMemAddr  output  64  fetch address; valid when IMemReq=1.
- IMemReady  input  1  one-cycle pulse: IMemData is valid for the oldest outstanding request.
- IMemData  input  32  returned instruction word.
- Stall  input  1  decode cannot accept the IF/ID contents this cycle.
- BranchTaken  input  1  the instruction in IF/ID is a taken branch (B, or CBZ with condition met).
- BusImm  input  64  sign-extended, pre-shifted (<<2) branch offset of the IF/ID instruction.
- Instruction  output  32  IF/ID instruction register.
- InstrPC  output  64  PC of Instruction.
- InstrValid  output  1  IF/ID register holds a valid instruction.

Behaviour:
- Reset: when Reset_L=0 at a clock edge:
  - PC<=RESET_PC, state<=S_ISSUE.
  - InstrValid<=0, Instruction<=0, InstrPC<=0, hold buffer cleared.
  - Reset overrides every other input, including mid-request; a late IMemReady after reset is ignored because state is S_ISSUE.
- IMemReq=1 only in S_ISSUE. IMemAddr=PC, combinational from the PC register. At most one request outstanding. Memory latency ≥1 cycle.
- Consume: occurs at an edge where InstrValid=1 and Stall=0. The slot is free this cycle if InstrValid=0 or a consume occurs.
- Redirect: occurs when a consume happens with BranchTaken=1.
  - Target = InstrPC + BusImm, modulo 2^64 (wrap-around, no overflow flag).
  - BranchTaken is ignored when InstrValid=0 or Stall=1.
- States:
  - S_ISSUE: assert IMemReq. If redirect, PC<=target, go to S_DRAIN. Otherwise go to S_WAIT.
  - S_WAIT:
    - Redirect with IMemReady in the same cycle: drop the data, PC<=target, go to S_ISSUE.
    - Redirect without IMemReady: PC<=target, go to S_DRAIN.
    - IMemReady with the slot free: Instruction<=IMemData, InstrPC<=PC, InstrValid<=1, PC<=PC+PC_STEP, go to S_ISSUE.
    - IMemReady with the slot not free: write {IMemData, PC} to the hold buffer, PC<=PC+PC_STEP, go to S_HOLD.
    - No IMemReady: stay.
  - S_DRAIN: IMemReq=0. On IMemReady, discard the data and go to S_ISSUE. Redirect is impossible here because InstrValid=0.
  - S_HOLD: IMemReq=0.
    - Redirect: clear the buffer, PC<=target, go to S_ISSUE.
    - Slot free: move the buffer to IF/ID with InstrValid<=1, go to S_ISSUE.
    - Otherwise stay.
- IF/ID update rules:
  - On redirect, InstrValid<=0 in that cycle; nothing loads, so the wrong path is squashed.
  - On a consume with nothing new to load, InstrValid<=0.
  - While Stall=1 and InstrValid=1, Instruction, InstrPC and InstrValid hold their values.
- Throughput: with 1-cycle memory and no stalls, one instruction every 2 cycles (issue then wait). Instruction order is preserved; an instruction is never duplicated or skipped except by a redirect.
- Outputs are registered, except IMemReq and IMemAddr, which decode the state and PC registers only. There are no combinational input-to-output paths.

Test Plan:
- Reset, then 1-cycle memory returning words 0xA0000000+n, Stall=0 -> IMemAddr sequence 0x0,0x4,0x8. InstrPC/Instruction pairs (0x0,0xA0000000), (0x4,0xA0000001). InstrValid rises 2 cycles after reset release.
- 3-cycle memory latency -> IMemReq pulses 4 cycles apart. Each word appears one cycle after its IMemReady, with the matching InstrPC.
- Stall=1 for 5 cycles while IF/ID holds PC 0x4 -> IF/ID stays at 0x4. PC 0x8 waits in S_HOLD with no IMemReq. After Stall drops, 0x4 is consumed, then 0x8 appears next cycle; nothing is lost or duplicated.
- CBZ at InstrPC 0x8, BusImm=0x40, BranchTaken=1, request for 0xC outstanding -> InstrValid drops, the 0xC response is discarded (S_DRAIN), next IMemAddr=0x48.
- B at InstrPC 0x10, BusImm=0xFFFFFFFFFFFFFFF0 -> next IMemAddr=0x0. Repeat with InstrPC=0x0 and the same BusImm -> IMemAddr=0xFFFFFFFFFFFFFFF0 (wrap).
- Reset_L=0 during S_WAIT with IMemReady arriving in the reset cycle -> InstrValid=0, next IMemAddr=RESET_PC, and the stale data never reaches Instruction.
